// File: rtl/crc_pkg.sv
// Shared CRC constants: codeword width, generator polynomials, field widths, FSM encodings.
// Latency: none (declarations only).
// Backpressure: n/a; shared with the encoder and the pattern generator.
package crc_pkg;

    localparam int MSG_W = 60;
    localparam int CNT_W = $clog2(MSG_W);

    localparam int CRC5_W = 5;
    localparam int CRC8_W = 8;
    localparam int SYN_W  = CRC8_W;

    // Generators with the implicit leading term dropped.
    localparam logic [CRC5_W-1:0] CRC5_POLY = 5'h05;  // x^5 + x^2 + 1
    localparam logic [CRC8_W-1:0] CRC8_POLY = 8'h07;  // x^8 + x^2 + x + 1

    // Mode select carried alongside each codeword.
    localparam logic MODE_CRC5 = 1'b0;
    localparam logic MODE_CRC8 = 1'b1;

    // FSM encodings; 2'b11 is unused and recovers to idle.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_W - 1);

    // Right-aligned data field of a codeword for the given mode.
    function automatic logic [MSG_W-1:0] data_field(input logic [MSG_W-1:0] cw, input logic mode);
        return (mode == MODE_CRC8) ? (cw >> CRC8_W) : (cw >> CRC5_W);
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit polynomial division step: shifts the next codeword bit into the remainder.
// Latency: combinational.
// Backpressure: none; caller decides when the step is committed.
module crc_lfsr_step
    import crc_pkg::*;
(
    input  logic             mode,
    input  logic [SYN_W-1:0] rem_cur,
    input  logic             bit_val,
    output logic [SYN_W-1:0] rem_nxt
);

    logic [CRC5_W-1:0] rem5;
    logic [CRC8_W-1:0] rem8;

    // Long division, MSB first: bring the new bit in at the bottom and subtract
    // the generator whenever the bit leaving the top is set. After the whole
    // codeword has been shifted in, the register holds codeword mod G, so a
    // valid codeword leaves zero and a single flipped bit k leaves x^k mod G.
    always_comb begin
        rem5    = {rem_cur[CRC5_W-2:0], bit_val} ^ (rem_cur[CRC5_W-1] ? CRC5_POLY : '0);
        rem8    = {rem_cur[CRC8_W-2:0], bit_val} ^ (rem_cur[CRC8_W-1] ? CRC8_POLY : '0);
        rem_nxt = (mode == MODE_CRC8) ? rem8 : {{(SYN_W-CRC5_W){1'b0}}, rem5};
    end

endmodule

// File: rtl/crc_checker.sv
// Receive-side CRC-5/CRC-8 checker: bit-serial division of a 60-bit codeword, reports syndrome and data.
// Latency: accepted at edge E0, one-cycle out_valid after edge E60; one codeword per 61 cycles.
// Backpressure: in_ready low while shifting; in_valid is ignored then, accepted in IDLE and DONE.
module crc_checker
    import crc_pkg::*;
(
    input  logic             clk_1,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             CRC,
    input  logic [MSG_W-1:0] message,
    output logic             in_ready,
    output logic             out_valid,
    output logic             crc_ok,
    output logic [SYN_W-1:0] syndrome,
    output logic [MSG_W-1:0] out
);

    logic [1:0]       state;
    logic [MSG_W-1:0] shift_reg;
    logic [MSG_W-1:0] data_q;
    logic [SYN_W-1:0] rem;
    logic [SYN_W-1:0] rem_step;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             accept;

    crc_lfsr_step u_step (
        .mode    (mode_q),
        .rem_cur (rem),
        .bit_val (shift_reg[MSG_W-1]),
        .rem_nxt (rem_step)
    );

    // Ready whenever not mid-division; the DONE cycle can take the next codeword back-to-back.
    always_comb begin
        in_ready = (state == ST_IDLE) || (state == ST_DONE);
        accept   = in_valid && in_ready;
    end

    // Capture, shift-divide and publish results; reset drops any partial codeword.
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            data_q    <= '0;
            rem       <= '0;
            cnt       <= '0;
            mode_q    <= MODE_CRC5;
            out_valid <= 1'b0;
            crc_ok    <= 1'b0;
            syndrome  <= '0;
            out       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        shift_reg <= message;
                        data_q    <= data_field(message, CRC);
                        mode_q    <= CRC;
                        rem       <= '0;
                        cnt       <= '0;
                        state     <= ST_SHIFT;
                    end else begin
                        state     <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    rem       <= rem_step;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Bit 0 is consumed on this edge, so rem_step is the final remainder.
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        syndrome  <= rem_step;
                        crc_ok    <= (rem_step == '0);
                        out       <= data_q;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_checker.sv
// Directed and randomized self-checking bench for crc_checker.
// Latency: checks 60-edge result latency and 61-cycle back-to-back spacing.
// Backpressure: drives in_valid during busy cycles and in DONE to exercise in_ready.
module tb_crc_checker;
    import crc_pkg::*;

    logic             clk_1 = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             CRC;
    logic [MSG_W-1:0] message;
    logic             in_ready;
    logic             out_valid;
    logic             crc_ok;
    logic [SYN_W-1:0] syndrome;
    logic [MSG_W-1:0] out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int strobes = 0;
    int accept_cyc = 0;
    int strobe_cyc = 0;

    crc_checker dut (
        .clk_1     (clk_1),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .CRC       (CRC),
        .message   (message),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .crc_ok    (crc_ok),
        .syndrome  (syndrome),
        .out       (out)
    );

    always #5 clk_1 = ~clk_1;

    always @(posedge clk_1) cyc <= cyc + 1;

    // out_valid is stable across the whole cycle, so one count per strobe cycle.
    always @(negedge clk_1) if (out_valid === 1'b1) strobes <= strobes + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain long division of the whole codeword by the full generator.
    function automatic logic [SYN_W-1:0] ref_rem(input logic [MSG_W-1:0] cw, input logic mode);
        logic [MSG_W-1:0] w;
        logic [MSG_W-1:0] g;
        int wd;
        w  = cw;
        wd = mode ? 8 : 5;
        g  = mode ? 60'h107 : 60'h025;
        for (int i = MSG_W - 1; i >= wd; i--)
            if (w[i]) w = w ^ (g << (i - wd));
        return mode ? w[7:0] : {3'b000, w[4:0]};
    endfunction

    task automatic send(input logic [MSG_W-1:0] m, input logic c);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk_1); #1;
            n++;
        end
        chk("ready_wait", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        message  = m;
        CRC      = c;
        @(posedge clk_1); #1;
        accept_cyc = cyc;
        in_valid   = 1'b0;
        message    = '0;
    endtask

    task automatic wait_result();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk_1); #1;
            if (out_valid === 1'b1) begin
                found      = 1'b1;
                strobe_cyc = cyc;
            end
        end
        chk("strobe_seen", {63'd0, found}, 64'd1);
    endtask

    task automatic run_vec(input string tag, input logic [MSG_W-1:0] m, input logic c,
                           input logic e_ok, input logic [7:0] e_syn, input logic [MSG_W-1:0] e_out);
        send(m, c);
        wait_result();
        chk({tag, "_lat"}, 64'(strobe_cyc - accept_cyc), 64'd60);
        chk({tag, "_ok"},  {63'd0, crc_ok}, {63'd0, e_ok});
        chk({tag, "_syn"}, {56'd0, syndrome}, {56'd0, e_syn});
        chk({tag, "_out"}, {4'd0, out}, {4'd0, e_out});
    endtask

    initial begin
        int s0, s1;
        logic             mode;
        logic [MSG_W-1:0] d, cw;
        logic [7:0]       exp_syn, held_syn;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        CRC      = 1'b0;
        message  = '0;
        repeat (3) @(posedge clk_1);
        #1;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_crc_ok",    {63'd0, crc_ok},    64'd0);
        chk("rst_syndrome",  {56'd0, syndrome},  64'd0);
        chk("rst_out",       {4'd0, out},        64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a division.
        send(60'h107, 1'b1);
        chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (19) @(posedge clk_1);
        #1;
        rst_n = 1'b0;
        @(posedge clk_1); #1;
        chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_syndrome",  {56'd0, syndrome},  64'd0);
        rst_n = 1'b1;
        s0 = strobes;
        repeat (80) @(posedge clk_1);
        #1;
        chk("midrst_no_strobe", 64'(strobes - s0), 64'd0);

        // Hand-computed vectors.
        run_vec("c8_pass", 60'h107, 1'b1, 1'b1, 8'h00, 60'h1);
        run_vec("c8_err",  60'h106, 1'b1, 1'b0, 8'h01, 60'h1);
        held_syn = syndrome;
        @(posedge clk_1); #1;
        chk("pulse_drop", {63'd0, out_valid}, 64'd0);
        chk("hold_syn",   {56'd0, syndrome}, {56'd0, held_syn});
        chk("hold_ok",    {63'd0, crc_ok}, 64'd0);
        run_vec("c8_zero", 60'h100, 1'b1, 1'b0, 8'h07, 60'h1);
        run_vec("c5_pass", 60'h025, 1'b0, 1'b1, 8'h00, 60'h1);
        run_vec("c5_zero", 60'h000, 1'b0, 1'b1, 8'h00, 60'h0);

        // in_valid held with junk while busy must not disturb the codeword in flight.
        send(60'h107, 1'b1);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            message  = {$urandom, $urandom};
            CRC      = 1'($urandom_range(1, 0));
            @(posedge clk_1); #1;
        end
        in_valid = 1'b0;
        wait_result();
        chk("hs_lat", 64'(strobe_cyc - accept_cyc), 64'd60);
        chk("hs_ok",  {63'd0, crc_ok}, 64'd1);
        chk("hs_syn", {56'd0, syndrome}, 64'd0);
        chk("hs_out", {4'd0, out}, 64'd1);

        // Back-to-back acceptance in the DONE cycle.
        send(60'h107, 1'b1);
        wait_result();
        s1 = strobe_cyc;
        chk("b2b_ready_done", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        message  = 60'h025;
        CRC      = 1'b0;
        @(posedge clk_1); #1;
        in_valid = 1'b0;
        chk("b2b_busy", {63'd0, in_ready}, 64'd0);
        wait_result();
        chk("b2b_gap", 64'(strobe_cyc - s1), 64'd61);
        chk("b2b_ok",  {63'd0, crc_ok}, 64'd1);
        chk("b2b_out", {4'd0, out}, 64'd1);

        // Randomized codewords against the division model.
        repeat (2) @(posedge clk_1);
        #1;
        s0 = strobes;
        for (int i = 0; i < 100; i++) begin
            mode = 1'($urandom_range(1, 0));
            d    = {$urandom, $urandom};
            cw   = mode ? (d << 8) : (d << 5);
            cw   = cw | 60'(ref_rem(cw, mode));
            if (i % 2 == 1) cw = cw ^ (60'd1 << $urandom_range(59, 0));
            exp_syn = ref_rem(cw, mode);
            send(cw, mode);
            wait_result();
            chk("rnd_syn", {56'd0, syndrome}, {56'd0, exp_syn});
            chk("rnd_ok",  {63'd0, crc_ok}, {63'd0, (exp_syn == 8'h00)});
            chk("rnd_out", {4'd0, out}, {4'd0, (mode ? (cw >> 8) : (cw >> 5))});
        end
        repeat (2) @(posedge clk_1);
        #1;
        chk("rnd_strobes", 64'(strobes - s0), 64'd100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
